// File: rtl/ervp_multimode_onehot_counter.sv
// ervp_multimode_onehot_counter
// One-hot position counter with runtime direction, step, active-range limit
// and direct index load. CIRCULAR selects wrap-around or saturation at the
// range ends. A binary index is registered alongside the one-hot vector.
// Wrap and clip events are reported as one-cycle registered pulses.
module ervp_multimode_onehot_counter #(
  parameter int COUNT_LENGTH = 8,
  parameter int INDEX_WIDTH  = $clog2(COUNT_LENGTH),
  parameter int RESET_INDEX  = 0,
  parameter int INIT_INDEX   = RESET_INDEX,
  parameter bit CIRCULAR     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    enable,
  input  logic                    init,
  input  logic                    load,
  input  logic [INDEX_WIDTH-1:0]  load_index,
  input  logic                    count,
  input  logic                    dir,
  input  logic [INDEX_WIDTH-1:0]  step,
  input  logic [INDEX_WIDTH-1:0]  limit,
  output logic [COUNT_LENGTH-1:0] value,
  output logic [INDEX_WIDTH-1:0]  index,
  output logic                    is_first_count,
  output logic                    is_last_count,
  output logic                    wrapped,
  output logic                    saturated
);

  // Native index width, one extra bit for sums up to 2*L+1, and a signed
  // form with room for the borrow of a downward step.
  typedef logic [INDEX_WIDTH-1:0]         idx_t;
  typedef logic [INDEX_WIDTH:0]           ext_t;
  typedef logic signed [INDEX_WIDTH+1:0]  sgn_t;
  typedef logic [COUNT_LENGTH-1:0]        vec_t;

  localparam ext_t MAX_POS    = ext_t'(COUNT_LENGTH - 1);
  localparam idx_t RESET_IDX  = idx_t'(RESET_INDEX);
  localparam idx_t INIT_IDX   = idx_t'(INIT_INDEX);
  localparam vec_t ONE_HOT_0  = vec_t'(1);
  localparam vec_t RESET_VEC  = ONE_HOT_0 << RESET_INDEX;

  idx_t index_q, index_d;
  vec_t value_q, value_d;
  logic wrapped_q, wrapped_d;
  logic saturated_q, saturated_d;

  ext_t lim_eff;     // effective highest active position L
  idx_t limit_idx;   // L in native width
  ext_t range_len;   // L + 1, the modulus in circular mode
  ext_t step_eff;    // step clamped to at most one full revolution
  ext_t sum_up;      // index + step_eff
  sgn_t diff_dn;     // index - step_eff, signed

  // Range/step conditioning and candidate next positions for both directions.
  always_comb begin
    lim_eff   = (ext_t'(limit) > MAX_POS) ? MAX_POS : ext_t'(limit);
    limit_idx = idx_t'(lim_eff);
    range_len = lim_eff + ext_t'(1);
    step_eff  = (ext_t'(step) > range_len) ? range_len : ext_t'(step);
    sum_up    = ext_t'(index_q) + step_eff;
    diff_dn   = sgn_t'({2'b00, index_q}) - sgn_t'({1'b0, step_eff});
  end

  // Next-state selection in priority order: enable, init, load, count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else chain can leave one unassigned and infer a latch.
    index_d     = index_q;
    wrapped_d   = 1'b0;
    saturated_d = 1'b0;

    if (!enable) begin
      index_d = index_q;
    end else if (init) begin
      index_d = INIT_IDX;
    end else if (load) begin
      if (ext_t'(load_index) > lim_eff) begin
        index_d     = limit_idx;
        saturated_d = 1'b1;
      end else begin
        index_d = load_index;
      end
    end else if (count && (step != '0)) begin
      if (ext_t'(index_q) > lim_eff) begin
        // Limit was lowered beneath the current position: pull back to L.
        index_d     = limit_idx;
        saturated_d = 1'b1;
      end else if (dir) begin
        if (sum_up <= lim_eff) begin
          index_d = idx_t'(sum_up);
        end else if (CIRCULAR) begin
          index_d   = idx_t'(sum_up - range_len);
          wrapped_d = 1'b1;
        end else begin
          index_d     = limit_idx;
          saturated_d = 1'b1;
        end
      end else begin
        if (!diff_dn[INDEX_WIDTH+1]) begin
          index_d = idx_t'(diff_dn);
        end else if (CIRCULAR) begin
          index_d   = idx_t'(diff_dn + sgn_t'({1'b0, range_len}));
          wrapped_d = 1'b1;
        end else begin
          index_d     = '0;
          saturated_d = 1'b1;
        end
      end
    end

    // The one-hot vector is decoded from the next index so both registers
    // always describe the same position.
    value_d = ONE_HOT_0 << index_d;
  end

  // State and event-pulse registers; pulses self-clear because their next
  // value defaults to zero, including while enable is low.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      index_q     <= RESET_IDX;
      value_q     <= RESET_VEC;
      wrapped_q   <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      index_q     <= index_d;
      value_q     <= value_d;
      wrapped_q   <= wrapped_d;
      saturated_q <= saturated_d;
    end
  end

  assign value     = value_q;
  assign index     = index_q;
  assign wrapped   = wrapped_q;
  assign saturated = saturated_q;

  // Position decode relative to the current direction of travel.
  assign is_first_count = dir ? (index_q == '0) : (ext_t'(index_q) == lim_eff);
  assign is_last_count  = dir ? (ext_t'(index_q) == lim_eff) : (index_q == '0);

endmodule

// File: tb/tb_ervp_multimode_onehot_counter.sv
// Scoreboard bench for ervp_multimode_onehot_counter: a circular and a
// saturating instance share one set of inputs; expected positions and pulses
// are hand-computed per vector, queued, and checked by a separate monitor.
module tb_ervp_multimode_onehot_counter;

  localparam int CL = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rstnn;
  logic          enable, init, load, count, dir;
  logic [IW-1:0] load_index, step, limit;

  logic [CL-1:0] c_value, s_value;
  logic [IW-1:0] c_index, s_index;
  logic          c_first, c_last, c_wrapped, c_saturated;
  logic          s_first, s_last, s_wrapped, s_saturated;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ci; bit cw; bit cs;
    int si; bit sw; bit ss;
    bit dr; int lim;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ervp_multimode_onehot_counter #(
    .COUNT_LENGTH(CL), .INDEX_WIDTH(IW), .RESET_INDEX(0), .INIT_INDEX(6), .CIRCULAR(1'b1)
  ) u_circ (
    .clk(clk), .rstnn(rstnn), .enable(enable), .init(init), .load(load),
    .load_index(load_index), .count(count), .dir(dir), .step(step), .limit(limit),
    .value(c_value), .index(c_index), .is_first_count(c_first), .is_last_count(c_last),
    .wrapped(c_wrapped), .saturated(c_saturated)
  );

  ervp_multimode_onehot_counter #(
    .COUNT_LENGTH(CL), .INDEX_WIDTH(IW), .RESET_INDEX(0), .INIT_INDEX(6), .CIRCULAR(1'b0)
  ) u_sat (
    .clk(clk), .rstnn(rstnn), .enable(enable), .init(init), .load(load),
    .load_index(load_index), .count(count), .dir(dir), .step(step), .limit(limit),
    .value(s_value), .index(s_index), .is_first_count(s_first), .is_last_count(s_last),
    .wrapped(s_wrapped), .saturated(s_saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference decode of first/last for a hand-computed index.
  function automatic bit first_of(input int idx, input bit dr, input int lim);
    int l;
    l = (lim >= CL) ? CL - 1 : lim;
    return dr ? (idx == 0) : (idx == l);
  endfunction

  function automatic bit last_of(input int idx, input bit dr, input int lim);
    int l;
    l = (lim >= CL) ? CL - 1 : lim;
    return dr ? (idx == l) : (idx == 0);
  endfunction

  // Monitor: one registered result per clock, sampled just after the edge
  // while the inputs that produced it are still applied.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("circ.index",     32'(c_index),     32'(mon_e.ci));
      check("circ.value",     32'(c_value),     32'(8'd1 << mon_e.ci));
      check("circ.wrapped",   32'(c_wrapped),   32'(mon_e.cw));
      check("circ.saturated", 32'(c_saturated), 32'(mon_e.cs));
      check("circ.first",     32'(c_first),     32'(first_of(mon_e.ci, mon_e.dr, mon_e.lim)));
      check("circ.last",      32'(c_last),      32'(last_of(mon_e.ci, mon_e.dr, mon_e.lim)));
      check("sat.index",      32'(s_index),     32'(mon_e.si));
      check("sat.value",      32'(s_value),     32'(8'd1 << mon_e.si));
      check("sat.wrapped",    32'(s_wrapped),   32'(mon_e.sw));
      check("sat.saturated",  32'(s_saturated), 32'(mon_e.ss));
      check("sat.first",      32'(s_first),     32'(first_of(mon_e.si, mon_e.dr, mon_e.lim)));
      check("sat.last",       32'(s_last),      32'(last_of(mon_e.si, mon_e.dr, mon_e.lim)));
    end
  end

  // Apply one vector at the falling edge and queue its expected result.
  task automatic cyc(input bit en, input bit ini, input bit ld, input int lidx,
                     input bit cnt, input bit dr, input int stp, input int lim,
                     input int ci, input bit cw, input bit cs,
                     input int si, input bit sw, input bit ss);
    exp_t e;
    @(negedge clk);
    enable     = en;
    init       = ini;
    load       = ld;
    load_index = IW'(lidx);
    count      = cnt;
    dir        = dr;
    step       = IW'(stp);
    limit      = IW'(lim);
    e.ci = ci; e.cw = cw; e.cs = cs;
    e.si = si; e.sw = sw; e.ss = ss;
    e.dr = dr; e.lim = lim;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rstnn = 1'b0;
    enable = 1'b0; init = 1'b0; load = 1'b0; count = 1'b0; dir = 1'b1;
    load_index = '0; step = 3'd1; limit = 3'd7;
    repeat (2) @(negedge clk);
    rstnn = 1'b1;

    // Count a little, then assert reset asynchronously in mid-count.
    cyc(1,0,0,0, 1,1,1,7,  1,0,0,  1,0,0);
    cyc(1,0,0,0, 1,1,1,7,  2,0,0,  2,0,0);
    drain();
    @(negedge clk);
    #2 rstnn = 1'b0;
    #1;
    check("rst.circ.index", 32'(c_index), 32'd0);
    check("rst.circ.value", 32'(c_value), 32'h01);
    check("rst.circ.pulse", 32'({c_wrapped, c_saturated}), 32'd0);
    check("rst.sat.index",  32'(s_index), 32'd0);
    check("rst.sat.value",  32'(s_value), 32'h01);
    check("rst.sat.pulse",  32'({s_wrapped, s_saturated}), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rstnn = 1'b1;

    // Enable low holds everything regardless of other controls.
    for (int i = 0; i < 4; i++)
      cyc(0,1,1,5, 1,1,1,7,  0,0,0,  0,0,0);

    // Circular up, step 3, limit 5, from 0.
    cyc(1,0,0,0, 1,1,3,5,  3,0,0,  3,0,0);
    cyc(1,0,0,0, 1,1,3,5,  0,1,0,  5,0,1);
    cyc(1,0,0,0, 1,1,3,5,  3,0,0,  5,0,1);
    cyc(1,0,0,0, 1,1,3,5,  0,1,0,  5,0,1);
    cyc(1,0,0,0, 1,1,3,5,  3,0,0,  5,0,1);

    // Down by 2 from index 3.
    cyc(1,0,1,3, 0,0,2,7,  3,0,0,  3,0,0);
    cyc(1,0,0,0, 1,0,2,7,  1,0,0,  1,0,0);
    cyc(1,0,0,0, 1,0,2,7,  7,1,0,  0,0,1);
    cyc(1,0,0,0, 1,0,2,7,  5,0,0,  0,0,1);

    // Load clamp beats count; init beats load.
    cyc(1,0,1,7, 1,1,1,4,  4,0,1,  4,0,1);
    cyc(1,1,1,7, 1,1,1,4,  6,0,0,  6,0,0);

    // Limit lowered under the position: change alone holds, count pulls back.
    cyc(1,0,0,0, 0,1,1,2,  6,0,0,  6,0,0);
    cyc(1,0,0,0, 1,1,1,2,  2,0,1,  2,0,1);
    cyc(1,1,0,0, 0,0,1,2,  6,0,0,  6,0,0);
    cyc(1,0,0,0, 1,0,1,2,  2,0,1,  2,0,1);

    // Full-revolution steps and step clamping.
    cyc(1,0,1,5, 0,1,7,6,  5,0,0,  5,0,0);
    cyc(1,0,0,0, 1,1,7,6,  5,1,0,  6,0,1);
    cyc(0,1,0,0, 1,1,7,6,  5,0,0,  6,0,0);
    cyc(1,0,1,2, 0,1,7,3,  2,0,0,  2,0,0);
    cyc(1,0,0,0, 1,1,7,3,  2,1,0,  3,0,1);
    cyc(1,0,0,0, 1,1,0,3,  2,0,0,  3,0,0);
    cyc(1,0,0,0, 1,0,4,3,  2,1,0,  0,0,1);
    cyc(1,0,0,0, 0,0,4,3,  2,0,0,  0,0,0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
